// File: rtl/ddsm_seq_pkg.sv
// Shared types and byte-slice positions for the DDSM FCW sequencer and its input delay stage.
// No logic; a 24-bit FCW is carried as MSB/ISB/LSB bytes at the offsets below.
package ddsm_seq_pkg;

    localparam int C_BYTE_W = 8;
    localparam int C_FCW_W  = 24;

    // Low bit of each byte inside an FCW; the delay stage slices with the same offsets.
    localparam int C_LSB_LO = 0;
    localparam int C_ISB_LO = 8;
    localparam int C_MSB_LO = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/ddsm_settle_cnt.sv
// Loadable down-counter with terminal-count flag; tc is high while the count sits at zero.
// Load takes effect on the next edge; the count saturates at zero and has no flow control.
module ddsm_settle_cnt #(
    parameter int P_W        = 3,
    parameter int P_LOAD_VAL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    logic [P_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= P_W'(P_LOAD_VAL);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ddsm_fcw_sequencer.sv
// Sequences FCW bytes into the staggered DDSM input stage and owns the modulator enable.
// A word is held P_SETTLE cycles after load; o_fcw_ready drops in LOAD/SETTLE/FLUSH.
module ddsm_fcw_sequencer
    import ddsm_seq_pkg::*;
#(
    parameter int P_SETTLE = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [C_FCW_W-1:0] i_fcw,
    input  logic               i_fcw_valid,
    output logic               o_fcw_ready,
    input  logic               i_start,
    input  logic               i_stop,
    output logic [C_BYTE_W-1:0] o_msb,
    output logic [C_BYTE_W-1:0] o_isb,
    output logic [C_BYTE_W-1:0] o_lsb,
    output logic               o_load,
    output logic               o_mod_en,
    output logic               o_sync,
    output logic               o_busy
);

    localparam int C_CNT_W = $clog2(P_SETTLE);

    state_t              state, state_n;
    logic [C_FCW_W-1:0]  shadow;
    logic                shadow_vld;
    logic                stop_pend, stop_pend_n;
    logic                run_origin;
    logic                hs;
    logic                cnt_load, cnt_tc;
    logic                load_word, zero_bytes;
    logic                mod_en_n, sync_n;
    logic [C_FCW_W-1:0]  fcw_sel;

    assign o_fcw_ready = ((state == S_IDLE) || (state == S_RUN)) && !i_rst;
    assign hs          = i_fcw_valid && o_fcw_ready;
    // A word arriving with the start beats the older shadow copy.
    assign fcw_sel     = hs ? i_fcw : shadow;

    // Loaded with P_SETTLE-1 so LOAD plus SETTLE, or all of FLUSH, spans P_SETTLE cycles.
    ddsm_settle_cnt #(
        .P_W        (C_CNT_W),
        .P_LOAD_VAL (P_SETTLE - 1)
    ) u_settle_cnt (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (cnt_load),
        .tc   (cnt_tc)
    );

    always_comb begin
        state_n     = state;
        cnt_load    = 1'b0;
        load_word   = 1'b0;
        zero_bytes  = 1'b0;
        mod_en_n    = o_mod_en;
        sync_n      = 1'b0;
        stop_pend_n = stop_pend;
        case (state)
            S_IDLE: begin
                if (i_start && (hs || shadow_vld)) begin
                    state_n   = S_LOAD;
                    cnt_load  = 1'b1;
                    load_word = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_SETTLE;
                if (i_stop) stop_pend_n = 1'b1;
            end
            S_SETTLE: begin
                if (cnt_tc) begin
                    if (stop_pend || i_stop) begin
                        state_n     = S_FLUSH;
                        cnt_load    = 1'b1;
                        zero_bytes  = 1'b1;
                        stop_pend_n = 1'b0;
                    end else begin
                        state_n  = S_RUN;
                        mod_en_n = 1'b1;
                        sync_n   = !run_origin;
                    end
                end else if (i_stop) begin
                    stop_pend_n = 1'b1;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_n    = S_FLUSH;
                    cnt_load   = 1'b1;
                    zero_bytes = 1'b1;
                end else if (hs) begin
                    state_n   = S_LOAD;
                    cnt_load  = 1'b1;
                    load_word = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_tc) begin
                    state_n  = S_IDLE;
                    mod_en_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            shadow     <= '0;
            shadow_vld <= 1'b0;
            stop_pend  <= 1'b0;
            run_origin <= 1'b0;
            o_msb      <= '0;
            o_isb      <= '0;
            o_lsb      <= '0;
            o_load     <= 1'b0;
            o_sync     <= 1'b0;
            o_mod_en   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state     <= state_n;
            stop_pend <= stop_pend_n;
            if (hs) begin
                shadow     <= i_fcw;
                shadow_vld <= 1'b1;
            end
            if (load_word) begin
                o_msb      <= fcw_sel[C_MSB_LO +: C_BYTE_W];
                o_isb      <= fcw_sel[C_ISB_LO +: C_BYTE_W];
                o_lsb      <= fcw_sel[C_LSB_LO +: C_BYTE_W];
                run_origin <= (state == S_RUN);
            end else if (zero_bytes) begin
                o_msb <= '0;
                o_isb <= '0;
                o_lsb <= '0;
            end
            o_load   <= load_word;
            o_sync   <= sync_n;
            o_mod_en <= mod_en_n;
            o_busy   <= (state_n == S_LOAD) || (state_n == S_SETTLE) || (state_n == S_FLUSH);
        end
    end

endmodule

// File: tb/tb_ddsm_fcw_sequencer.sv
// Bench for ddsm_fcw_sequencer: a deadline-based reference model queues expected outputs per edge,
// and a monitor compares them one edge later.
module tb_ddsm_fcw_sequencer;

    localparam int P = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] fcw = '0;
    logic        fcw_valid = 1'b0;
    logic        fcw_ready;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  msb, isb, lsb;
    logic        load, mod_en, sync, busy;

    always #5 clk = ~clk;

    ddsm_fcw_sequencer #(.P_SETTLE(P)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_fcw       (fcw),
        .i_fcw_valid (fcw_valid),
        .o_fcw_ready (fcw_ready),
        .i_start     (start),
        .i_stop      (stop),
        .o_msb       (msb),
        .o_isb       (isb),
        .o_lsb       (lsb),
        .o_load      (load),
        .o_mod_en    (mod_en),
        .o_sync      (sync),
        .o_busy      (busy)
    );

    typedef struct packed {
        logic        ready;
        logic        load;
        logic        sync;
        logic        en;
        logic        busy;
        logic [23:0] bytes;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the block is either idle, running, or inside a hold window
    // that ends at an absolute edge number (a settle window or a flush window).
    int          m_now = 0;
    int          m_hold_end = 0;
    bit          m_in_hold = 0;
    bit          m_hold_is_flush = 0;
    bit          m_running = 0;
    bit          m_from_run = 0;
    bit          m_stop_req = 0;
    bit          m_en = 0;
    bit          m_load = 0;
    bit          m_sync = 0;
    bit          m_shv = 0;
    bit          m_hs = 0;
    logic [23:0] m_bytes = '0;
    logic [23:0] m_shadow = '0;

    task automatic step(input logic [23:0] w, input logic v, input logic st,
                        input logic sp, input logic r);
        bit   can_take;
        int   e;
        obs_t o;
        @(negedge clk);
        fcw = w; fcw_valid = v; start = st; stop = sp; rst = r;
        e        = m_now + 1;
        m_now    = e;
        can_take = !r && !m_in_hold;
        m_hs     = v && can_take;
        m_load   = 0;
        m_sync   = 0;
        if (r) begin
            m_in_hold = 0; m_hold_is_flush = 0; m_running = 0; m_from_run = 0;
            m_stop_req = 0; m_en = 0; m_bytes = '0; m_shadow = '0; m_shv = 0;
        end else if (m_in_hold) begin
            if (sp && !m_hold_is_flush) m_stop_req = 1;
            if (e == m_hold_end) begin
                if (m_hold_is_flush) begin
                    m_in_hold = 0; m_running = 0; m_en = 0;
                end else if (m_stop_req) begin
                    m_bytes = '0; m_hold_is_flush = 1; m_hold_end = e + P; m_stop_req = 0;
                end else begin
                    m_in_hold = 0; m_running = 1;
                    if (!m_from_run) begin
                        m_en = 1; m_sync = 1;
                    end
                end
            end
        end else begin
            if (m_hs) begin
                m_shadow = w; m_shv = 1;
            end
            if (m_running && sp) begin
                m_bytes = '0; m_in_hold = 1; m_hold_is_flush = 1; m_hold_end = e + P;
            end else if ((m_running && m_hs) || (!m_running && st && m_shv)) begin
                m_bytes = m_shadow; m_load = 1; m_in_hold = 1; m_hold_is_flush = 0;
                m_from_run = m_running; m_stop_req = 0; m_hold_end = e + P;
            end
        end
        o.ready = !r && !m_in_hold;
        o.load  = m_load;
        o.sync  = m_sync;
        o.en    = m_en;
        o.busy  = m_in_hold;
        o.bytes = m_bytes;
        exp_q.push_back(o);
    endtask

    always @(posedge clk) begin
        obs_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {fcw_ready, load, sync, mod_en, busy, msb, isb, lsb};
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got rdy=%b load=%b sync=%b en=%b busy=%b bytes=%h, required rdy=%b load=%b sync=%b en=%b busy=%b bytes=%h",
                         $time, g.ready, g.load, g.sync, g.en, g.busy, g.bytes,
                         e.ready, e.load, e.sync, e.en, e.busy, e.bytes);
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [23:0] w);
        bit taken;
        taken = 0;
        for (int k = 0; k < 4 * P && !taken; k++) begin
            step(w, 1'b1, 1'b0, 1'b0, 1'b0);
            taken = m_hs;
        end
        if (!taken) begin
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", w, 4 * P);
        end
    endtask

    initial begin
        step('0, 0, 0, 0, 1);
        step('0, 0, 0, 0, 1);
        // Start with no word ever accepted: nothing happens.
        step('0, 0, 1, 0, 0);
        step('0, 0, 1, 0, 0);
        idle(2);
        // Handshake in IDLE, start two edges later.
        step(24'h123456, 1, 0, 0, 0);
        idle(1);
        step('0, 0, 1, 0, 0);
        idle(P + 3);
        // Back-to-back words while running.
        send(24'hABCDEF);
        send(24'h000001);
        idle(P + 2);
        // Stop and word in the same RUN cycle, then restart from the shadow.
        step(24'h777777, 1, 0, 1, 0);
        idle(P + 2);
        step('0, 0, 1, 0, 0);
        idle(P + 3);
        step('0, 0, 0, 1, 0);
        idle(P + 2);
        // Stop during the initial settle.
        step('0, 0, 1, 0, 0);
        idle(1);
        step('0, 0, 0, 1, 0);
        idle(2 * P + 3);
        // Reset mid-settle.
        step('0, 0, 1, 0, 0);
        idle(2);
        step('0, 0, 0, 0, 1);
        step(24'hFFFFFF, 1, 0, 0, 1);
        idle(2);
        step('0, 0, 1, 0, 0);
        idle(3);
        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step($urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(2);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
